// File: rtl/img_ctrl_pkg.sv
// Shared types for the image pipeline mode controller: FSM states, mode pair, frame counter width.
package img_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PEND  = 2'd1,
    FLUSH = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    logic gray;
    logic horz;
  } img_mode_t;

  localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/sw_sync_debounce.sv
// Two-flop synchroniser plus stability counter for a bank of raw switches;
// o_req follows the synced value only after it has held steady for DEB_CYC clocks.
module sw_sync_debounce #(
  parameter int               WIDTH   = 2,
  parameter int               DEB_CYC = 50000,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_sw,
  output logic [WIDTH-1:0] o_req
);

  localparam int             CNT_W   = $clog2(DEB_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYC - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_last;
  logic [WIDTH-1:0] r_req;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= RST_VAL;
      r_sync2 <= RST_VAL;
      r_last  <= RST_VAL;
      r_req   <= RST_VAL;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_sw;
      r_sync2 <= r_sync1;
      r_last  <= r_sync2;
      // Any movement of the synced pair restarts the stability window.
      if (r_sync2 != r_last) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_req <= r_sync2;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_req = r_req;

endmodule

// File: rtl/image_proc_mode_ctrl.sv
// Run-time mode sequencer for the grayscale/convolution pipeline: applies debounced switch
// requests only at start-of-frame and masks output while stale data drains. Optional macro: FRAME_CNT_EN.
module image_proc_mode_ctrl
  import img_ctrl_pkg::*;
#(
  parameter int         IMG_W       = 640,
  parameter int         FLUSH_LINES = 2,
  parameter int         PIPE_LAT    = 4,
  parameter int         DEB_CYC     = 50000,
  parameter logic [1:0] RST_MODE    = 2'b00
) (
  input  logic                   iCLK,
  input  logic                   iRST,
  input  logic                   iSW_GRAY,
  input  logic                   iSW_HORZ,
  input  logic [10:0]            iX_Cont,
  input  logic [10:0]            iY_Cont,
  input  logic                   iDVAL,
  output logic                   oGRAY_EN,
  output logic                   oHORZ_EN,
  output logic                   oMASK,
  output logic                   oBUSY,
  output logic [FRAME_CNT_W-1:0] oFRAME_CNT
);

  localparam int               FLUSH_LEN = FLUSH_LINES * IMG_W + PIPE_LAT;
  localparam int               CNT_W     = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(FLUSH_LEN - 1);

  logic [1:0]  w_req_bits;
  img_mode_t   w_req;
  logic        w_sof;
  logic        w_chg;

  ctrl_state_t r_state;
  img_mode_t   r_active;
  img_mode_t   r_pend;
  logic [CNT_W-1:0] r_cnt;
  logic        r_mask;
  logic        r_busy;

  sw_sync_debounce #(
    .WIDTH   (2),
    .DEB_CYC (DEB_CYC),
    .RST_VAL (RST_MODE)
  ) u_sw_sync_debounce (
    .i_clk (iCLK),
    .i_rst (iRST),
    .i_sw  ({iSW_GRAY, iSW_HORZ}),
    .o_req (w_req_bits)
  );

  assign w_req = img_mode_t'(w_req_bits);
  assign w_sof = iDVAL && (iX_Cont == 11'd0) && (iY_Cont == 11'd0);
  assign w_chg = (w_req != r_active);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state  <= RUN;
      r_active <= img_mode_t'(RST_MODE);
      r_pend   <= img_mode_t'(RST_MODE);
      r_cnt    <= '0;
      r_mask   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_chg) begin
            r_state <= PEND;
            r_pend  <= w_req;
            r_busy  <= 1'b1;
          end
        end
        PEND: begin
          r_pend <= w_req;
          // A withdrawn request takes priority over a coincident start-of-frame.
          if (!w_chg) begin
            r_state <= RUN;
            r_busy  <= 1'b0;
          end else if (w_sof) begin
            r_active <= r_pend;
            r_cnt    <= CNT_LOAD;
            r_state  <= FLUSH;
            r_mask   <= 1'b1;
          end
        end
        FLUSH: begin
          if (iDVAL) begin
            if (r_cnt == '0) begin
              r_mask <= 1'b0;
              if (w_chg) begin
                r_state <= PEND;
                r_pend  <= w_req;
              end else begin
                r_state <= RUN;
                r_busy  <= 1'b0;
              end
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
        end
        default: begin
          r_state <= RUN;
          r_mask  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign oGRAY_EN = r_active.gray;
  assign oHORZ_EN = r_active.horz;
  assign oMASK    = r_mask;
  assign oBUSY    = r_busy;

`ifdef FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] r_frame_cnt;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_frame_cnt <= '0;
    end else if (w_sof) begin
      r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
    end
  end

  assign oFRAME_CNT = r_frame_cnt;
`else
  assign oFRAME_CNT = '0;
`endif

endmodule

// File: tb/tb_image_proc_mode_ctrl.sv
// Bench for image_proc_mode_ctrl: directed sequences, a debounce vector table, and
// randomized switch/pixel traffic checked every cycle against a behavioural model.
module tb_image_proc_mode_ctrl;

  localparam int IMG_W = 8;
  localparam int IMG_H = 4;
  localparam int FLINES = 2;
  localparam int PLAT = 4;
  localparam int DEB = 4;
  localparam int FLEN = FLINES * IMG_W + PLAT;
`ifdef FRAME_CNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  logic        iCLK;
  logic        iRST;
  logic        iSW_GRAY;
  logic        iSW_HORZ;
  logic [10:0] iX_Cont;
  logic [10:0] iY_Cont;
  logic        iDVAL;
  logic        oGRAY_EN;
  logic        oHORZ_EN;
  logic        oMASK;
  logic        oBUSY;
  logic [15:0] oFRAME_CNT;

  image_proc_mode_ctrl #(
    .IMG_W       (IMG_W),
    .FLUSH_LINES (FLINES),
    .PIPE_LAT    (PLAT),
    .DEB_CYC     (DEB),
    .RST_MODE    (2'b00)
  ) dut (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .iSW_GRAY   (iSW_GRAY),
    .iSW_HORZ   (iSW_HORZ),
    .iX_Cont    (iX_Cont),
    .iY_Cont    (iY_Cont),
    .iDVAL      (iDVAL),
    .oGRAY_EN   (oGRAY_EN),
    .oHORZ_EN   (oHORZ_EN),
    .oMASK      (oMASK),
    .oBUSY      (oBUSY),
    .oFRAME_CNT (oFRAME_CNT)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  int px = 0;
  int py = 0;
  bit busy_seen, mask_seen;

  // Behavioural reference: switch sample history, applied mode, pixels left to mask.
  logic [1:0]  hist [0:DEB+2];
  logic [1:0]  m_req, m_active, m_prev_req;
  bit          m_pending;
  int          m_rem;
  logic [15:0] m_frames;
  bit          m_sof, m_stable;

  always @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      for (int i = 0; i <= DEB + 2; i++) hist[i] = 2'b00;
      m_req = 2'b00; m_active = 2'b00; m_prev_req = 2'b00;
      m_pending = 1'b0; m_rem = 0; m_frames = 16'h0;
    end else begin
      m_sof = iDVAL && (iX_Cont == 11'd0) && (iY_Cont == 11'd0);
      if (m_rem > 0) begin
        if (iDVAL) begin
          m_rem = m_rem - 1;
          if (m_rem == 0) m_pending = (m_req != m_active);
        end
      end else if (m_pending) begin
        if (m_req == m_active) m_pending = 1'b0;
        else if (m_sof) begin
          m_active = m_prev_req;
          m_rem = FLEN;
        end
      end else begin
        m_pending = (m_req != m_active);
      end
      m_prev_req = m_req;
      if (m_sof) m_frames = m_frames + 16'd1;
      for (int i = DEB + 2; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {iSW_GRAY, iSW_HORZ};
      // Accepted once the synced sample (two clocks old) matched for DEB+1 samples.
      m_stable = 1'b1;
      for (int i = 3; i <= DEB + 2; i++) if (hist[i] != hist[2]) m_stable = 1'b0;
      if (m_stable) m_req = hist[2];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit dv, output bit sof);
    sof = dv && (px == 0) && (py == 0);
    iDVAL = dv;
    iX_Cont = 11'(px);
    iY_Cont = 11'(py);
    @(posedge iCLK); #1;
    if (dv) begin
      px++;
      if (px == IMG_W) begin
        px = 0;
        py++;
        if (py == IMG_H) py = 0;
      end
    end
    if (oBUSY) busy_seen = 1'b1;
    if (oMASK) mask_seen = 1'b1;
  endtask

  typedef struct {
    int len;
    bit exp_busy;
  } deb_vec_t;

  deb_vec_t dvec [5];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit s, found, early;
    int cnt, sofs;

    dvec[0] = '{len: 1, exp_busy: 1'b0};
    dvec[1] = '{len: 3, exp_busy: 1'b0};
    dvec[2] = '{len: 4, exp_busy: 1'b0};
    dvec[3] = '{len: 5, exp_busy: 1'b1};
    dvec[4] = '{len: 9, exp_busy: 1'b1};

    iRST = 1'b1; iSW_GRAY = 1'b0; iSW_HORZ = 1'b0;
    iDVAL = 1'b0; iX_Cont = '0; iY_Cont = '0;
    repeat (2) @(posedge iCLK);
    #1;
    check("rst_outputs", {28'h0, oGRAY_EN, oHORZ_EN, oMASK, oBUSY}, 32'h0);
    check("rst_frame_cnt", {16'h0, oFRAME_CNT}, 32'h0);
    iRST = 1'b0;
    chk_en = 1'b1;

    fork
      forever begin
        @(negedge iCLK);
        if (chk_en)
          check("model", {14'h0, oGRAY_EN, oHORZ_EN, oMASK, oBUSY, oFRAME_CNT},
                {14'h0, m_active, (m_rem > 0), (m_rem > 0) || m_pending,
                 (FC_EN ? m_frames : 16'h0)});
      end
    join_none

    // Debounce: short glitches must never open a request.
    for (int k = 0; k < 5; k++) begin
      busy_seen = 1'b0; mask_seen = 1'b0;
      iSW_GRAY = 1'b1;
      repeat (dvec[k].len) cyc(1'b0, s);
      iSW_GRAY = 1'b0;
      repeat (20) cyc(1'b0, s);
      check($sformatf("deb_len%0d_busy", dvec[k].len), 32'(busy_seen), 32'(dvec[k].exp_busy));
      check($sformatf("deb_len%0d_idle", dvec[k].len), {30'h0, mask_seen, oBUSY}, 32'h0);
    end

    // Apply at SOF, then measure the mask length with iDVAL gaps.
    repeat (10) cyc(1'b1, s);
    iSW_GRAY = 1'b1;
    repeat (12) cyc(1'b1, s);
    check("t3_pend", {30'h0, oBUSY, oGRAY_EN}, 32'h2);
    found = 1'b0; early = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      cyc(1'b1, s);
      if (s) found = 1'b1;
      else if (oGRAY_EN) early = 1'b1;
    end
    check("t3_sof_found", 32'(found), 32'h1);
    check("t3_no_early_apply", 32'(early), 32'h0);
    check("t3_applied", {29'h0, oGRAY_EN, oHORZ_EN, oMASK}, 32'h5);
    cnt = 0;
    for (int k = 0; k < 200 && oMASK; k++) begin
      cyc((k % 3) != 2, s);
      if ((k % 3) != 2) cnt++;
    end
    check("t4_mask_pixels", 32'(cnt), 32'(FLEN));
    check("t4_done", {30'h0, oMASK, oBUSY}, 32'h0);

    // Withdrawal: request back to the active mode before any SOF.
    busy_seen = 1'b0; mask_seen = 1'b0;
    iSW_GRAY = 1'b0;
    repeat (12) cyc(1'b0, s);
    iSW_GRAY = 1'b1;
    repeat (25) cyc(1'b0, s);
    check("t5a_busy_seen", 32'(busy_seen), 32'h1);
    check("t5a_no_mask", 32'(mask_seen), 32'h0);
    check("t5a_final", {29'h0, oGRAY_EN, oHORZ_EN, oBUSY}, 32'h4);

    // Request changed during FLUSH is taken up at the following SOF.
    iSW_HORZ = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin cyc(1'b1, s); found = s; end
    check("t5b_apply1", {29'h0, oGRAY_EN, oHORZ_EN, oMASK}, 32'h7);
    iSW_GRAY = 1'b0; iSW_HORZ = 1'b0;
    for (int k = 0; k < 100 && oMASK; k++) cyc(1'b1, s);
    check("t5b_exit_to_pend", {28'h0, oGRAY_EN, oHORZ_EN, oMASK, oBUSY}, 32'hD);
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin cyc(1'b1, s); found = s; end
    check("t5b_apply2", {29'h0, oGRAY_EN, oHORZ_EN, oMASK}, 32'h1);
    repeat (3) cyc(1'b1, s);

    // Reset while flushing: outputs clear without a clock edge.
    check("t1_in_flush", 32'(oMASK), 32'h1);
    iRST = 1'b1;
    #1;
    check("t1_async_rst", {28'h0, oGRAY_EN, oHORZ_EN, oMASK, oBUSY}, 32'h0);
    check("t1_rst_frame_cnt", {16'h0, oFRAME_CNT}, 32'h0);
    px = 0; py = 0;
    repeat (2) cyc(1'b0, s);
    iRST = 1'b0;

    // Frame counter over three SOFs.
    sofs = 0;
    for (int k = 0; k < 200 && sofs < 3; k++) begin
      cyc(1'b1, s);
      if (s) sofs++;
    end
    check("t6_frame_cnt", {16'h0, oFRAME_CNT}, FC_EN ? 32'd3 : 32'd0);

    // Randomized traffic against the reference model.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 29) == 0) iSW_GRAY = ~iSW_GRAY;
      if ($urandom_range(0, 29) == 0) iSW_HORZ = ~iSW_HORZ;
      cyc($urandom_range(0, 3) != 0, s);
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
